// File: rtl/fp_result_buffer_pkg.sv
// Shared FP constants, flag bundle and classifier
// for the add/sub result path.
package fp_result_buffer_pkg;

   localparam logic [31:0] SIGN_MASK = 32'h8000_0000;
   localparam logic [31:0] EXP_MASK  = 32'h7F80_0000;
   localparam logic [31:0] MANT_MASK = 32'h007F_FFFF;

   localparam logic ADD_SEL = 1'b0;
   localparam logic SUB_SEL = 1'b1;

   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
      logic subnormal;
      logic sign;
   } fp_flags_t;

   function automatic fp_flags_t fp_classify(
      input logic [31:0] word
   );
      fp_flags_t f;
      logic e1;
      logic e0;
      logic m0;
      e1 = (word & EXP_MASK) == EXP_MASK;
      e0 = (word & EXP_MASK) == 32'h0;
      m0 = (word & MANT_MASK) == 32'h0;
      f.nan       = e1 & ~m0;
      f.inf       = e1 & m0;
      f.zero      = e0 & m0;
      f.subnormal = e0 & ~m0;
      f.sign      = (word & SIGN_MASK) != 32'h0;
      return f;
   endfunction

endpackage

// File: rtl/fp_result_buffer_if.sv
// Issue/credit and result-output bundle
// between operand source, buffer and consumer.
interface fp_result_buffer_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 3
);
   import fp_result_buffer_pkg::*;

   logic             issue_valid;
   logic             issue_op;
   logic             issue_ready;
   logic [WIDTH-1:0] result;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_op;
   fp_flags_t        out_flags;
   logic [CNT_W-1:0] count;
   logic             overflow_err;

   modport master (
      output issue_valid,
      output issue_op,
      output result,
      output out_ready,
      input  issue_ready,
      input  out_valid,
      input  out_data,
      input  out_op,
      input  out_flags,
      input  count,
      input  overflow_err
   );

   modport slave (
      input  issue_valid,
      input  issue_op,
      input  result,
      input  out_ready,
      output issue_ready,
      output out_valid,
      output out_data,
      output out_op,
      output out_flags,
      output count,
      output overflow_err
   );

endinterface

// File: rtl/fp_result_buffer_fifo.sv
// Synchronous show-ahead FIFO; head is
// visible on rdata while not empty.
module fp_result_buffer_fifo #(
   parameter int W     = 38,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         assert (!(pop && empty));
      end
   end

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   // Empty head reads as zero so stale entries never leak out
   assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fp_result_buffer.sv
// Tracks issued add/subs through the adder latency,
// classifies and queues results, returns issue credit.
module fp_result_buffer
   import fp_result_buffer_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int EXP_W   = 8,
   parameter int MANT_W  = 23,
   parameter int LATENCY = 1,
   parameter int DEPTH   = 4
) (
   input logic               clk,
   input logic               rst,
   fp_result_buffer_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int FL_W  = $bits(fp_flags_t);
   localparam int FW    = WIDTH + 1 + FL_W;

   logic               rst_q;
   logic [LATENCY-1:0] tag_v;
   logic [LATENCY-1:0] tag_op;
   logic               ready;
   logic               acc;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic               err_q;
   logic [CNT_W-1:0]   count;
   logic [31:0]        occ;
   logic [EXP_W-1:0]   exp_f;
   logic [MANT_W-1:0]  man_f;
   fp_flags_t          flags;
   logic [FW-1:0]      wdata;
   logic [FW-1:0]      rdata;

   assign exp_f = bus.result[WIDTH-2:MANT_W];
   assign man_f = bus.result[MANT_W-1:0];

   always_comb begin
      flags           = '0;
      flags.nan       = (&exp_f) & (|man_f);
      flags.inf       = (&exp_f) & ~(|man_f);
      flags.zero      = ~(|exp_f) & ~(|man_f);
      flags.subnormal = ~(|exp_f) & (|man_f);
      flags.sign      = bus.result[WIDTH-1];
   end

   // Queued plus in-flight work must fit the FIFO
   always_comb begin
      occ = 32'(count);
      for (int i = 0; i < LATENCY; i++) begin
         occ = occ + 32'(tag_v[i]);
      end
   end

   assign ready = ~rst & ~rst_q & (occ < 32'(DEPTH));
   assign acc   = bus.issue_valid & ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q  <= 1'b1;
         tag_v  <= '0;
         tag_op <= '0;
         err_q  <= 1'b0;
      end else begin
         rst_q     <= 1'b0;
         tag_v[0]  <= acc;
         tag_op[0] <= acc & bus.issue_op;
         for (int i = 1; i < LATENCY; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_op[i] <= tag_op[i-1];
         end
         if (bus.issue_valid && !ready) begin
            err_q <= 1'b1;
         end
         assert (!(push && full && !pop));
         if (push) begin
            assert ($onehot0({flags.nan, flags.inf,
                              flags.zero, flags.subnormal}));
         end
      end
   end

   assign push  = tag_v[LATENCY-1];
   assign pop   = ~empty & bus.out_ready;
   assign wdata = {bus.result, tag_op[LATENCY-1], flags};

   fp_result_buffer_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (wdata),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign bus.issue_ready  = ready;
   assign bus.out_valid    = ~empty;
   assign bus.out_data     = rdata[FW-1 -: WIDTH];
   assign bus.out_op       = rdata[FL_W];
   assign bus.out_flags    = fp_flags_t'(rdata[FL_W-1:0]);
   assign bus.count        = count;
   assign bus.overflow_err = err_q;

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed bench for fp_result_buffer with a
// one-cycle adder stand-in driving result.
module tb_fp_result_buffer;
   import fp_result_buffer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] res_in;
   int          total  = 0;
   int          passed = 0;
   int          n_acc;

   logic [31:0] bp_res [4];
   logic        bp_op  [4];
   logic [4:0]  bp_fl  [4];

   fp_result_buffer_if #(.WIDTH(32), .CNT_W(3)) bi ();

   fp_result_buffer #(
      .WIDTH   (32),
      .EXP_W   (8),
      .MANT_W  (23),
      .LATENCY (1),
      .DEPTH   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bi)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) bi.result <= res_in;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h",
                  tag, obs, exp);
   endtask

   task automatic issue(input logic op,
                        input logic [31:0] r);
      bi.issue_valid = 1'b1;
      bi.issue_op    = op;
      res_in         = r;
      step();
      bi.issue_valid = 1'b0;
   endtask

   initial begin
      bp_res = '{32'hFF80_0000, 32'h0000_0001,
                 32'h8000_0000, 32'h3F80_0000};
      bp_op  = '{ADD_SEL, SUB_SEL, ADD_SEL, SUB_SEL};
      bp_fl  = '{5'b01001, 5'b00010, 5'b00101, 5'b00000};

      rst            = 1'b1;
      bi.issue_valid = 1'b0;
      bi.issue_op    = 1'b0;
      bi.out_ready   = 1'b0;
      res_in         = '0;
      step();
      step();
      chk("rst_valid", 64'(bi.out_valid), 64'd0);
      chk("rst_count", 64'(bi.count), 64'd0);
      chk("rst_ready", 64'(bi.issue_ready), 64'd0);
      chk("rst_err", 64'(bi.overflow_err), 64'd0);
      chk("rst_data", 64'(bi.out_data), 64'd0);
      chk("rst_op", 64'(bi.out_op), 64'd0);
      chk("rst_flags", 64'(bi.out_flags), 64'd0);
      rst = 1'b0;
      chk("ready_lag", 64'(bi.issue_ready), 64'd0);
      step();
      chk("ready_up", 64'(bi.issue_ready), 64'd1);

      // 1.0 + 2.0
      bi.out_ready = 1'b1;
      issue(ADD_SEL, 32'h4040_0000);
      chk("add_lat1", 64'(bi.out_valid), 64'd0);
      step();
      chk("add_valid", 64'(bi.out_valid), 64'd1);
      chk("add_data", 64'(bi.out_data), 64'h4040_0000);
      chk("add_flags", 64'(bi.out_flags), 64'd0);
      chk("add_op", 64'(bi.out_op), 64'(ADD_SEL));
      step();
      chk("add_pop", 64'(bi.count), 64'd0);

      // NaN result
      issue(ADD_SEL, 32'h7FC0_0000);
      step();
      chk("nan_flags", 64'(bi.out_flags), 64'h10);
      chk("nan_exp", 64'(bi.out_data[30:23]), 64'hFF);
      step();

      // 0 - 0
      issue(SUB_SEL, 32'h0000_0000);
      step();
      chk("zero_data", 64'(bi.out_data), 64'd0);
      chk("zero_flags", 64'(bi.out_flags), 64'h04);
      chk("zero_op", 64'(bi.out_op), 64'(SUB_SEL));
      step();

      // Backpressure: source honours credit
      bi.out_ready = 1'b0;
      n_acc = 0;
      for (int k = 0; k < 6; k++) begin
         if (bi.issue_ready && n_acc < 4) begin
            bi.issue_valid = 1'b1;
            bi.issue_op    = bp_op[n_acc];
            res_in         = bp_res[n_acc];
            n_acc++;
         end else begin
            bi.issue_valid = 1'b0;
         end
         step();
      end
      bi.issue_valid = 1'b0;
      chk("bp_accepted", 64'(n_acc), 64'd4);
      chk("bp_count", 64'(bi.count), 64'd4);
      chk("bp_ready", 64'(bi.issue_ready), 64'd0);
      chk("bp_err", 64'(bi.overflow_err), 64'd0);
      chk("bp_head", 64'(bi.out_data), 64'(bp_res[0]));
      step();
      chk("bp_hold", 64'(bi.out_data), 64'(bp_res[0]));

      // Overflow while full
      bi.issue_valid = 1'b1;
      bi.issue_op    = ADD_SEL;
      res_in         = 32'hDEAD_BEEF;
      step();
      step();
      bi.issue_valid = 1'b0;
      step();
      chk("ovf_err", 64'(bi.overflow_err), 64'd1);
      chk("ovf_count", 64'(bi.count), 64'd4);
      chk("ovf_head", 64'(bi.out_data), 64'(bp_res[0]));

      // Drain in issue order
      bi.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drn_valid", 64'(bi.out_valid), 64'd1);
         chk("drn_data", 64'(bi.out_data), 64'(bp_res[i]));
         chk("drn_op", 64'(bi.out_op), 64'(bp_op[i]));
         chk("drn_flags", 64'(bi.out_flags), 64'(bp_fl[i]));
         step();
      end
      chk("drn_empty", 64'(bi.out_valid), 64'd0);
      chk("drn_count", 64'(bi.count), 64'd0);
      chk("drn_ready", 64'(bi.issue_ready), 64'd1);
      chk("err_sticky", 64'(bi.overflow_err), 64'd1);

      // Reset with 3 queued + 1 in flight
      bi.out_ready = 1'b0;
      issue(ADD_SEL, 32'h1111_1111);
      issue(ADD_SEL, 32'h2222_2222);
      issue(SUB_SEL, 32'h3333_3333);
      issue(ADD_SEL, 32'h4444_4444);
      chk("mf_count", 64'(bi.count), 64'd3);
      rst = 1'b1;
      step();
      chk("mf_valid", 64'(bi.out_valid), 64'd0);
      chk("mf_cnt0", 64'(bi.count), 64'd0);
      chk("mf_err", 64'(bi.overflow_err), 64'd0);
      rst          = 1'b0;
      bi.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mf_stale", 64'(bi.out_valid), 64'd0);
      end
      chk("mf_ready", 64'(bi.issue_ready), 64'd1);
      issue(ADD_SEL, 32'h4000_0000);
      step();
      chk("mf_new", 64'(bi.out_data), 64'h4000_0000);
      chk("mf_newcnt", 64'(bi.count), 64'd1);
      step();
      chk("mf_end", 64'(bi.count), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
